// File: rtl/snes_joy_serializer_pkg.sv
// Shared constants for the SNES pad serializer.
// Button bit positions and the idle (nothing pressed) pad word.
package snes_joy_pkg;
   localparam int unsigned C_BTN_B      = 0;
   localparam int unsigned C_BTN_Y      = 1;
   localparam int unsigned C_BTN_SELECT = 2;
   localparam int unsigned C_BTN_START  = 3;
   localparam int unsigned C_BTN_UP     = 4;
   localparam int unsigned C_BTN_DOWN   = 5;
   localparam int unsigned C_BTN_LEFT   = 6;
   localparam int unsigned C_BTN_RIGHT  = 7;
   localparam int unsigned C_BTN_A      = 8;
   localparam int unsigned C_BTN_X      = 9;
   localparam int unsigned C_BTN_L      = 10;
   localparam int unsigned C_BTN_R      = 11;
   localparam logic [15:0] C_SNES_JOY_IDLE = 16'hFFFF;
endpackage

// File: rtl/snes_joy_serializer_if.sv
// Controller-port bus between main and the serializer.
// master = main (strobe/clock), slave = pad emulation (data/done).
interface snes_joy_serializer_if
   import snes_joy_pkg::*;
   #(parameter int C_players = 2);
   logic                 joy_strb;
   logic [C_players-1:0] joy_clk;
   logic [C_players-1:0] joy_di;
   logic [C_players-1:0] done;
   modport master (output joy_strb, output joy_clk,
                   input  joy_di,   input  done);
   modport slave  (input  joy_strb, input  joy_clk,
                   output joy_di,   output done);
endinterface

// File: rtl/snes_joy_serializer_channel.sv
// One controller port: latch, rising-edge shift, saturating
// bit counter and done flag.
module snes_joy_channel
   import snes_joy_pkg::*;
   #(parameter int   C_bits = 16,
     parameter logic C_fill = 1'b0)
   (input  logic              clk,
    input  logic              reset,
    input  logic [C_bits-1:0] eff_i,
    input  logic              strb_i,
    input  logic              joy_clk_i,
    output logic              joy_di_o,
    output logic              done_o);

   localparam int CW = $clog2(C_bits + 1);

   logic [C_bits-1:0] shift_q, shift_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              clk_last_q;

   // Next state: strobe latches and wins over any edge.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (strb_i) begin
         shift_d = eff_i;
         cnt_d   = '0;
      end else if (joy_clk_i && !clk_last_q) begin
         shift_d = {C_fill, shift_q[C_bits-1:1]};
         if (cnt_q != CW'(C_bits))
            cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers; clk_last starts high so release gives no edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q    <= '1;
         cnt_q      <= CW'(C_bits);
         clk_last_q <= 1'b1;
      end else begin
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         clk_last_q <= joy_clk_i;
      end
   end

   assign joy_di_o = shift_q[0];
   assign done_o   = (cnt_q == CW'(C_bits));
endmodule

// File: rtl/snes_joy_serializer.sv
// SNES controller-port emulation for C_players pads.
// Optional autofire divider enabled by macro JOY_TURBO_EN.
module snes_joy_serializer
   import snes_joy_pkg::*;
   #(parameter int   C_players   = 2,
     parameter int   C_bits      = 16,
     parameter logic C_fill      = 1'b0,
     parameter int   C_turbo_div = 357955)
   (input  logic                          clk,
    input  logic                          reset,
    input  logic [C_players*C_bits-1:0]   buttons_n,
    input  logic [C_players*C_bits-1:0]   turbo_mask,
    snes_joy_serializer_if.slave          joy);

   logic [C_players*C_bits-1:0] eff;

`ifdef JOY_TURBO_EN
   localparam int TW = (C_turbo_div > 1) ? $clog2(C_turbo_div) : 1;

   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          phase_q, phase_d;

   // Free-running divider; phase flips each time it wraps.
   always_comb begin
      tcnt_d  = tcnt_q + 1'b1;
      phase_d = phase_q;
      if (tcnt_q == TW'(C_turbo_div - 1)) begin
         tcnt_d  = '0;
         phase_d = ~phase_q;
      end
   end

   // Divider registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         tcnt_q  <= tcnt_d;
         phase_q <= phase_d;
      end
   end

   assign eff = buttons_n
              | (turbo_mask & {(C_players*C_bits){phase_q}});
`else
   logic unused_turbo;
   assign unused_turbo = ^turbo_mask;
   assign eff = buttons_n;
`endif

   for (genvar p = 0; p < C_players; p++) begin : g_ch
      snes_joy_channel #(
         .C_bits (C_bits),
         .C_fill (C_fill)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .eff_i     (eff[p*C_bits +: C_bits]),
         .strb_i    (joy.joy_strb),
         .joy_clk_i (joy.joy_clk[p]),
         .joy_di_o  (joy.joy_di[p]),
         .done_o    (joy.done[p])
      );
   end
endmodule

// File: tb/tb_snes_joy_serializer.sv
// Directed bench for snes_joy_serializer (2 ports, 16 bits).
// Inputs change after negedge, outputs checked at next negedge.
module tb_snes_joy_serializer;
   import snes_joy_pkg::*;

   localparam int   NP = 2;
   localparam int   NB = 16;
   localparam logic FILL = 1'b0;

   logic clk;
   logic reset;
   logic [NP*NB-1:0] buttons_n;
   logic [NP*NB-1:0] turbo_mask;
   int chk;
   int fail;

   snes_joy_serializer_if #(.C_players(NP)) j ();

   snes_joy_serializer #(
      .C_players   (NP),
      .C_bits      (NB),
      .C_fill      (FILL),
      .C_turbo_div (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .buttons_n  (buttons_n),
      .turbo_mask (turbo_mask),
      .joy        (j.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic edge_p(input int p);
      j.joy_clk[p] = 1'b1;
      @(negedge clk);
      j.joy_clk[p] = 1'b0;
      @(negedge clk);
   endtask

   task automatic strobe1;
      j.joy_strb = 1'b1;
      @(negedge clk);
      j.joy_strb = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk++;
      if (j.joy_di !== 2'b11 || j.done !== 2'b11) begin
         fail++;
         $display("FAIL reset_state di=%b done=%b want 11/11",
                  j.joy_di, j.done);
      end
      buttons_n[NB-1:0] = 16'hFFFE;
      strobe1();
      repeat (5) edge_p(0);
      chk++;
      if (j.done[0] !== 1'b0 || j.joy_di[0] !== 1'b1) begin
         fail++;
         $display("FAIL mid_shift di=%b done=%b want 1/0",
                  j.joy_di[0], j.done[0]);
      end
      j.joy_clk[0] = 1'b1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk++;
      if (j.joy_di !== 2'b11 || j.done !== 2'b11) begin
         fail++;
         $display("FAIL reset_abort di=%b done=%b want 11/11",
                  j.joy_di, j.done);
      end
      j.joy_clk[0] = 1'b0;
      @(negedge clk);
      edge_p(0);
      chk++;
      if (j.joy_di !== 2'b11 || j.done !== 2'b11) begin
         fail++;
         $display("FAIL reset_edge di=%b done=%b want 11/11",
                  j.joy_di, j.done);
      end
   endtask

   task automatic test_shift;
      buttons_n[NB-1:0] = 16'hFFFE;
      strobe1();
      @(negedge clk);
      chk++;
      if (j.joy_di[0] !== 1'b0 || j.done[0] !== 1'b0) begin
         fail++;
         $display("FAIL latch_b di=%b done=%b want 0/0",
                  j.joy_di[0], j.done[0]);
      end
      for (int k = 1; k <= 18; k++) begin
         logic ed;
         logic ex;
         edge_p(0);
         ex = (k < NB) ? 1'b1 : FILL;
         ed = (k >= NB);
         chk++;
         if (j.joy_di[0] !== ex || j.done[0] !== ed) begin
            fail++;
            $display("FAIL shift_e%0d di=%b done=%b want %b/%b",
                     k, j.joy_di[0], j.done[0], ex, ed);
         end
      end
   endtask

   task automatic test_strobe_edge;
      j.joy_clk[0] = 1'b0;
      @(negedge clk);
      buttons_n[NB-1:0] = 16'hFFFE;
      j.joy_strb = 1'b1;
      j.joy_clk[0] = 1'b1;
      @(negedge clk);
      j.joy_strb = 1'b0;
      chk++;
      if (j.joy_di[0] !== 1'b0 || j.done[0] !== 1'b0) begin
         fail++;
         $display("FAIL strb_edge di=%b done=%b want 0/0",
                  j.joy_di[0], j.done[0]);
      end
      @(negedge clk);
      chk++;
      if (j.joy_di[0] !== 1'b0) begin
         fail++;
         $display("FAIL strb_edge_hold di=%b want 0",
                  j.joy_di[0]);
      end
      j.joy_clk[0] = 1'b0;
      @(negedge clk);
      edge_p(0);
      chk++;
      if (j.joy_di[0] !== 1'b1) begin
         fail++;
         $display("FAIL strb_edge_next di=%b want 1",
                  j.joy_di[0]);
      end
   endtask

   task automatic test_strobe_hold;
      for (int i = 0; i < 10; i++) begin
         logic b;
         b = i[0];
         buttons_n[NB-1:0] = {15'h7FFF, b};
         j.joy_strb = 1'b1;
         j.joy_clk[0] = b;
         @(negedge clk);
         chk++;
         if (j.joy_di[0] !== b || j.done[0] !== 1'b0) begin
            fail++;
            $display("FAIL hold_%0d di=%b done=%b want %b/0",
                     i, j.joy_di[0], j.done[0], b);
         end
      end
      j.joy_strb = 1'b0;
      j.joy_clk[0] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_independent;
      logic [NB-1:0] v0;
      logic [NB-1:0] v1;
      v0 = 16'hA5C3;
      v1 = 16'h3C5A;
      buttons_n = {v1, v0};
      strobe1();
      @(negedge clk);
      chk++;
      if (j.joy_di !== {v1[0], v0[0]}) begin
         fail++;
         $display("FAIL indep_latch di=%b want %b%b",
                  j.joy_di, v1[0], v0[0]);
      end
      for (int k = 1; k <= NB; k++) begin
         logic ex;
         logic ed;
         edge_p(1);
         ex = (k < NB) ? v1[k] : FILL;
         ed = (k == NB);
         chk++;
         if (j.joy_di[1] !== ex || j.done[1] !== ed
             || j.joy_di[0] !== v0[0] || j.done[0] !== 1'b0) begin
            fail++;
            $display("FAIL indep_e%0d di=%b done=%b want %b%b/%b0",
                     k, j.joy_di, j.done, ex, v0[0], ed);
         end
      end
   endtask

   task automatic test_turbo;
      logic s [24];
      buttons_n[NB-1:0] = 16'hFFFE;
      turbo_mask[NB-1:0] = 16'h0001;
      j.joy_strb = 1'b1;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         s[i] = j.joy_di[0];
      end
      j.joy_strb = 1'b0;
      turbo_mask = '0;
`ifdef JOY_TURBO_EN
      begin
         int t;
         t = -1;
         for (int i = 1; i < 24; i++)
            if (t < 0 && s[i] !== s[i-1]) t = i;
         chk++;
         if (t < 1 || t > 4) begin
            fail++;
            $display("FAIL turbo_start t=%0d want 1..4", t);
         end else begin
            for (int i = t; i < 24; i++) begin
               logic ex;
               ex = s[t] ^ 1'(((i - t) / 4) & 1);
               chk++;
               if (s[i] !== ex) begin
                  fail++;
                  $display("FAIL turbo_%0d di=%b want %b",
                           i, s[i], ex);
               end
            end
         end
      end
`else
      for (int i = 0; i < 24; i++) begin
         chk++;
         if (s[i] !== 1'b0) begin
            fail++;
            $display("FAIL noturbo_%0d di=%b want 0", i, s[i]);
         end
      end
`endif
      @(negedge clk);
   endtask

   initial begin
      chk = 0;
      fail = 0;
      reset = 1'b1;
      buttons_n = {NP{C_SNES_JOY_IDLE}};
      turbo_mask = '0;
      j.joy_strb = 1'b0;
      j.joy_clk = '0;
      test_reset();
      test_shift();
      test_strobe_edge();
      test_strobe_hold();
      test_independent();
      test_turbo();
      $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
      $finish;
   end
endmodule
